multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register; stable from DECODE until FETCH.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg  output  2 each  datapath mux/ALU selects.
REQ-008 state  output  4  current state code (debug).
REQ-009 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-010 illegal_op  output  1  sticky illegal-opcode flag (see REQ-026).

Function
REQ-011 The block SHALL be a Moore FSM; outputs decode from state, except IRWrite/PCWrite in FETCH and the advance out of memory states, which are qualified by mem_ready.
REQ-012 Any output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready; stay until mem_ready, then DECODE.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next: 0->EXECUTE, 8/12->IMM_EXEC, 35/43->MEM_ADDR, 4->BRANCH, 3->JAL, other->REQ-026.
REQ-015 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALU_WB: RegDst=01, MemtoReg=00, RegWrite=1 -> FETCH.
REQ-016 IMM_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 (ADDI) or 11 (ANDI) -> IMM_WB: RegDst=00, MemtoReg=00, RegWrite=1 -> FETCH.
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->MEM_READ (35) or MEM_WRITE (43).
REQ-018 MEM_READ: MemRead=1, IorD=1; hold until mem_ready, then MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1 -> FETCH.
REQ-019 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready, then FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
REQ-021 JAL: RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1, PCSource=10 -> FETCH.
REQ-022 Zero-wait latency (cycles): R/ADDI/ANDI 4, LW 5, SW 4, BEQ 3, JAL 3; each mem_ready-low cycle in a memory state adds one.
REQ-023 instr_done SHALL be high in ALU_WB, IMM_WB, MEM_WB, BRANCH, JAL, and MEM_WRITE when mem_ready=1.
REQ-024 MemRead and MemWrite SHALL never be high together; write enables SHALL not assert in states other than those listed.

Reset
REQ-025 While reset is high, state=FETCH, illegal_op=0, and all outputs SHALL be 0 (reset gates outputs); first fetch begins the cycle after deassertion; reset mid-instruction abandons it with no further writes.

Configuration
REQ-026 With ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> TRAP (all controls 0, illegal_op=1, no exit except reset); without it: unknown opcode -> FETCH as a NOP with instr_done=1 in DECODE, and illegal_op tied 0.

Structure
REQ-027 Package mc_ctrl_pkg SHALL hold opcode constants (RFORMAT 0, JAL 3, BEQ 4, ADDI 8, ANDI 12, LW 35, SW 43), 4-bit state codes, and ALUOp/PCSource/RegDst/MemtoReg encodings.
REQ-028 One sub-module, mc_ctrl_decode (combinational state->control decode), SHALL be instantiated; state register and next-state logic stay in the top.

Verification
REQ-029 opcode=0, mem_ready=1 -> FETCH, DECODE, EXECUTE, ALU_WB; RegWrite=1 with RegDst=01 on cycle 4; instr_done on cycle 4.
REQ-030 opcode=35, mem_ready low 3 cycles in MEM_READ -> MemRead=1, IorD=1 held 4 cycles; MEM_WB on cycle 8 with MemtoReg=01.
REQ-031 opcode=4 -> PCWriteCond=1, PCSource=01, ALUOp=01 in cycle 3 only; back in FETCH cycle 4.
REQ-032 opcode=3 -> cycle 3 RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10; opcode=12 -> IMM_EXEC ALUOp=11.
REQ-033 opcode=43, reset asserted during MEM_WRITE with mem_ready=0 -> MemWrite drops to 0 immediately, state=FETCH, no write after release.
REQ-034 opcode=63 -> with ILLEGAL_TRAP_EN: state TRAP, illegal_op=1 until reset; without: FETCH on cycle 3, illegal_op=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared encodings for the multicycle MIPS-style control unit.
//   - opcode constants for the supported instruction subset
//   - 4-bit FSM state codes (also driven on the debug 'state' port)
//   - ALUOp / ALUSrcB / PCSource / RegDst / MemtoReg select encodings
//   - is_known_op(): true for every opcode the FSM can execute
// Optional feature macro used by the importing files: ILLEGAL_TRAP_EN
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RFORMAT = 6'd0;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_ADDI    = 6'd8;
  localparam logic [5:0] OP_ANDI    = 6'd12;
  localparam logic [5:0] OP_LW      = 6'd35;
  localparam logic [5:0] OP_SW      = 6'd43;

  // FSM state codes
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXECUTE   = 4'd2,
    S_ALU_WB    = 4'd3,
    S_IMM_EXEC  = 4'd4,
    S_IMM_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Next-PC source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Destination register select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register write-data select
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OP_RFORMAT, OP_JAL, OP_BEQ, OP_ADDI,
      OP_ANDI, OP_LW, OP_SW: known = 1'b1;
      default:               known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational state -> datapath control decode for multicycle_control.
// Every control defaults to 0; each state only raises what it needs.
// Ports:
//   state_i      current state code
//   opcode_i     instruction opcode (selects ADDI/ANDI ALU op, NOP detection)
//   mem_ready_i  memory handshake (qualifies IRWrite/PCWrite and SW completion)
//   *_o          raw (not reset-gated) datapath controls and instr_done
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode traps instead of NOP)
// -----------------------------------------------------------------------------
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       instr_done_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_REG;
    alu_op_o        = ALUOP_ADD;
    pc_source_o     = PCSRC_ALU;
    reg_dst_o       = REGDST_RT;
    mem_to_reg_o    = M2R_ALU;
    instr_done_o    = 1'b0;

    case (state_t'(state_i))
      S_FETCH: begin
        // PC+4 computed every fetch cycle, but only committed (together
        // with the instruction word) once memory has delivered it.
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) into ALUOut.
        alu_src_b_o = SRCB_BRANCH;
`ifdef ILLEGAL_TRAP_EN
        instr_done_o = 1'b0;
`else
        // Unknown opcodes retire here as a NOP.
        instr_done_o = !is_known_op(opcode_i);
`endif
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        reg_dst_o    = REGDST_RD;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_IMM_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = (opcode_i == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_IMM_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_o = M2R_MEM;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEM_WRITE: begin
        // A store finishes in the cycle memory accepts it.
        mem_write_o  = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALUOP_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCSRC_ALUOUT;
        instr_done_o    = 1'b1;
      end
      S_JAL: begin
        reg_dst_o    = REGDST_RA;
        mem_to_reg_o = M2R_PC;
        reg_write_o  = 1'b1;
        pc_write_o   = 1'b1;
        pc_source_o  = PCSRC_JUMP;
        instr_done_o = 1'b1;
      end
      default: begin
        // S_TRAP and unused codes: everything stays 0.
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle MIPS-subset datapath
// (R-type, ADDI, ANDI, LW, SW, BEQ, JAL).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset; also forces all controls to 0
//   opcode       instruction[31:26], stable from DECODE until next FETCH
//   mem_ready    memory handshake, access completes in the cycle it is high
//   PCWrite .. MemtoReg   datapath controls / selects
//   state        current state code (debug)
//   instr_done   pulse in the last cycle of every instruction
//   illegal_op   sticky illegal-opcode flag
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcode enters TRAP (held until reset), illegal_op=1
//   undefined : unknown opcode retires as a NOP from DECODE, illegal_op=0
// -----------------------------------------------------------------------------
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RFORMAT:     state_d = S_EXECUTE;
          OP_ADDI,
          OP_ANDI:        state_d = S_IMM_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_JAL:         state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:        state_d = S_TRAP;
`else
          default:        state_d = S_FETCH;
`endif
        endcase
      end
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_IMM_EXEC:  state_d = S_IMM_WB;
      S_IMM_WB:    state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;   // only reset leaves the trap
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register (and sticky illegal flag when trapping is built in)
  // ---------------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Set on the same edge that enters TRAP, so the flag and the TRAP state
  // become visible together.
  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign illegal_op = 1'b0;
`endif

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic       dec_pc_write;
  logic       dec_pc_write_cond;
  logic       dec_i_or_d;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_ir_write;
  logic       dec_reg_write;
  logic       dec_alu_src_a;
  logic [1:0] dec_alu_src_b;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_pc_source;
  logic [1:0] dec_reg_dst;
  logic [1:0] dec_mem_to_reg;
  logic       dec_instr_done;

  mc_ctrl_decode u_decode (
    .state_i         (state_q),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (dec_pc_write),
    .pc_write_cond_o (dec_pc_write_cond),
    .i_or_d_o        (dec_i_or_d),
    .mem_read_o      (dec_mem_read),
    .mem_write_o     (dec_mem_write),
    .ir_write_o      (dec_ir_write),
    .reg_write_o     (dec_reg_write),
    .alu_src_a_o     (dec_alu_src_a),
    .alu_src_b_o     (dec_alu_src_b),
    .alu_op_o        (dec_alu_op),
    .pc_source_o     (dec_pc_source),
    .reg_dst_o       (dec_reg_dst),
    .mem_to_reg_o    (dec_mem_to_reg),
    .instr_done_o    (dec_instr_done)
  );

  // Reset forces every control low immediately, so an instruction in flight
  // (e.g. a stalled store) cannot write anything once reset rises, even
  // though FETCH itself would raise MemRead.
  logic       run;
  logic [1:0] run2;

  assign run  = ~reset;
  assign run2 = {2{run}};

  assign PCWrite     = dec_pc_write      & run;
  assign PCWriteCond = dec_pc_write_cond & run;
  assign IorD        = dec_i_or_d        & run;
  assign MemRead     = dec_mem_read      & run;
  assign MemWrite    = dec_mem_write     & run;
  assign IRWrite     = dec_ir_write      & run;
  assign RegWrite    = dec_reg_write     & run;
  assign ALUSrcA     = dec_alu_src_a     & run;
  assign ALUSrcB     = dec_alu_src_b     & run2;
  assign ALUOp       = dec_alu_op        & run2;
  assign PCSource    = dec_pc_source     & run2;
  assign RegDst      = dec_reg_dst       & run2;
  assign MemtoReg    = dec_mem_to_reg    & run2;
  assign instr_done  = dec_instr_done    & run;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed, cycle-by-cycle check of multicycle_control. Each cycle the full
// control word and the state code are compared against hand-written values.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  // Observed control word, field order matches cw() below.
  logic [31:0] ctl;
  assign ctl = {12'd0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg,
                instr_done, illegal_op};

  function automatic logic [31:0] cw(
    input logic pcw, input logic pcwc, input logic iord, input logic mrd,
    input logic mwr, input logic irw, input logic rw, input logic srca,
    input logic [1:0] srcb, input logic [1:0] aluop, input logic [1:0] pcsrc,
    input logic [1:0] regdst, input logic [1:0] m2r, input logic done,
    input logic ill);
    return {12'd0, pcw, pcwc, iord, mrd, mwr, irw, rw, srca, srcb, aluop,
            pcsrc, regdst, m2r, done, ill};
  endfunction

  //                                  pcw pcwc iord mrd mwr irw rw srca srcb   aluop  pcsrc  regdst m2r    done ill
  localparam logic [31:0] E_ZERO   = cw(0, 0,   0,   0,  0,  0,  0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_FETCH1 = cw(1, 0,   0,   1,  0,  1,  0, 0,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_FETCH0 = cw(0, 0,   0,   1,  0,  0,  0, 0,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_DECODE = cw(0, 0,   0,   0,  0,  0,  0, 0,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_DECNOP = cw(0, 0,   0,   0,  0,  0,  0, 0,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,   0);
  localparam logic [31:0] E_EXEC   = cw(0, 0,   0,   0,  0,  0,  0, 1,  2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_ALUWB  = cw(0, 0,   0,   0,  0,  0,  1, 0,  2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1,   0);
  localparam logic [31:0] E_ADDI   = cw(0, 0,   0,   0,  0,  0,  0, 1,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_ANDI   = cw(0, 0,   0,   0,  0,  0,  0, 1,  2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_IMMWB  = cw(0, 0,   0,   0,  0,  0,  1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1,   0);
  localparam logic [31:0] E_MADDR  = cw(0, 0,   0,   0,  0,  0,  0, 1,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_MREAD  = cw(0, 0,   1,   1,  0,  0,  0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_MWB    = cw(0, 0,   0,   0,  0,  0,  1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1,   0);
  localparam logic [31:0] E_MWR0   = cw(0, 0,   1,   0,  1,  0,  0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0);
  localparam logic [31:0] E_MWR1   = cw(0, 0,   1,   0,  1,  0,  0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1,   0);
  localparam logic [31:0] E_BR     = cw(0, 1,   0,   0,  0,  0,  0, 1,  2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1,   0);
  localparam logic [31:0] E_JAL    = cw(1, 0,   0,   0,  0,  0,  1, 0,  2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 1,   0);
  localparam logic [31:0] E_TRAP   = cw(0, 0,   0,   0,  0,  0,  0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1);

  // Expected state codes, written out numerically.
  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_EXEC = 4'd2,
                         ST_ALUWB = 4'd3,  ST_IMMEX  = 4'd4,  ST_IMMWB = 4'd5,
                         ST_MADDR = 4'd6,  ST_MREAD  = 4'd7,  ST_MWB   = 4'd8,
                         ST_MWR   = 4'd9,  ST_BR     = 4'd10, ST_JAL   = 4'd11,
                         ST_TRAP  = 4'd12;

  task automatic check_vec(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive mem_ready, sample mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic mr, input logic [3:0] es,
                      input logic [31:0] ec);
    mem_ready = mr;
    @(negedge clk);
    check_vec({tag, ".state"}, {28'd0, state}, {28'd0, es});
    check_vec({tag, ".ctl"}, ctl, ec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset     = 1'b1;
    opcode    = OP_RFORMAT;
    mem_ready = 1'b1;

    // Reset: FETCH state, every output 0 even with mem_ready high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("reset.state", {28'd0, state}, {28'd0, ST_FETCH});
    check_vec("reset.ctl", ctl, E_ZERO);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("reset released, first fetch next");

    // R-type, zero wait: 4 cycles.
    opcode = 6'd0;
    step("r.c1", 1, ST_FETCH,  E_FETCH1);
    step("r.c2", 1, ST_DECODE, E_DECODE);
    step("r.c3", 1, ST_EXEC,   E_EXEC);
    step("r.c4", 1, ST_ALUWB,  E_ALUWB);
    $display("instr R-type: 4 cycles checked");

    // ADDI: 4 cycles, ALUOp add.
    opcode = 6'd8;
    step("addi.c1", 1, ST_FETCH,  E_FETCH1);
    step("addi.c2", 1, ST_DECODE, E_DECODE);
    step("addi.c3", 1, ST_IMMEX,  E_ADDI);
    step("addi.c4", 1, ST_IMMWB,  E_IMMWB);
    $display("instr ADDI: 4 cycles checked");

    // ANDI: IMM_EXEC uses ALUOp 11.
    opcode = 6'd12;
    step("andi.c1", 1, ST_FETCH,  E_FETCH1);
    step("andi.c2", 1, ST_DECODE, E_DECODE);
    step("andi.c3", 1, ST_IMMEX,  E_ANDI);
    step("andi.c4", 1, ST_IMMWB,  E_IMMWB);
    $display("instr ANDI: 4 cycles checked");

    // LW with three wait cycles in MEM_READ: MEM_WB on cycle 8.
    opcode = 6'd35;
    step("lw.c1", 1, ST_FETCH,  E_FETCH1);
    step("lw.c2", 1, ST_DECODE, E_DECODE);
    step("lw.c3", 1, ST_MADDR,  E_MADDR);
    step("lw.c4", 0, ST_MREAD,  E_MREAD);
    step("lw.c5", 0, ST_MREAD,  E_MREAD);
    step("lw.c6", 0, ST_MREAD,  E_MREAD);
    step("lw.c7", 1, ST_MREAD,  E_MREAD);
    step("lw.c8", 1, ST_MWB,    E_MWB);
    $display("instr LW (3 waits): 8 cycles checked");

    // SW with one wait: instr_done only when memory accepts.
    opcode = 6'd43;
    step("sw.c1", 1, ST_FETCH,  E_FETCH1);
    step("sw.c2", 1, ST_DECODE, E_DECODE);
    step("sw.c3", 1, ST_MADDR,  E_MADDR);
    step("sw.c4", 0, ST_MWR,    E_MWR0);
    step("sw.c5", 1, ST_MWR,    E_MWR1);
    $display("instr SW (1 wait): 5 cycles checked");

    // BEQ with one fetch wait: IRWrite/PCWrite low while stalled.
    opcode = 6'd4;
    step("beq.c0", 0, ST_FETCH,  E_FETCH0);
    step("beq.c1", 1, ST_FETCH,  E_FETCH1);
    step("beq.c2", 1, ST_DECODE, E_DECODE);
    step("beq.c3", 1, ST_BR,     E_BR);
    $display("instr BEQ (fetch wait): 4 cycles checked");

    // JAL: 3 cycles; following FETCH confirms BEQ/JAL return on cycle 4.
    opcode = 6'd3;
    step("jal.c1", 1, ST_FETCH,  E_FETCH1);
    step("jal.c2", 1, ST_DECODE, E_DECODE);
    step("jal.c3", 1, ST_JAL,    E_JAL);
    $display("instr JAL: 3 cycles checked");

    // SW interrupted by reset while stalled in MEM_WRITE.
    opcode = 6'd43;
    step("swrst.c1", 1, ST_FETCH,  E_FETCH1);
    step("swrst.c2", 1, ST_DECODE, E_DECODE);
    step("swrst.c3", 1, ST_MADDR,  E_MADDR);
    mem_ready = 1'b0;
    @(negedge clk);
    check_vec("swrst.c4.state", {28'd0, state}, {28'd0, ST_MWR});
    check_vec("swrst.c4.ctl", ctl, E_MWR0);
    #1 reset = 1'b1;
    #1;
    check_vec("swrst.inrst.state", {28'd0, state}, {28'd0, ST_FETCH});
    check_vec("swrst.inrst.ctl", ctl, E_ZERO);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    step("swrst.rel1", 0, ST_FETCH, E_FETCH0);
    step("swrst.rel2", 0, ST_FETCH, E_FETCH0);
    $display("instr SW aborted by reset: checked");

    // Unknown opcode 63.
    opcode = 6'd63;
    step("ill.c1", 1, ST_FETCH, E_FETCH1);
`ifdef ILLEGAL_TRAP_EN
    step("ill.c2", 1, ST_DECODE, E_DECODE);
    step("ill.c3", 1, ST_TRAP,   E_TRAP);
    step("ill.c4", 1, ST_TRAP,   E_TRAP);
    opcode = 6'd0;
    step("ill.c5", 1, ST_TRAP,   E_TRAP);
    reset = 1'b1;
    @(negedge clk);
    check_vec("ill.rst.state", {28'd0, state}, {28'd0, ST_FETCH});
    check_vec("ill.rst.ctl", ctl, E_ZERO);
    @(posedge clk);
    #1 reset = 1'b0;
    step("ill.after", 1, ST_FETCH, E_FETCH1);
    $display("instr illegal 63: trap held until reset, checked");
`else
    step("ill.c2", 1, ST_DECODE, E_DECNOP);
    step("ill.c3", 1, ST_FETCH,  E_FETCH1);
    $display("instr illegal 63: retired as NOP, checked");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
